stream_to_apb_bridge: RTL and testbench
=======================================

Name: stream_to_apb_bridge

Overview:
- Byte-stream to APB master bridge; the next generation of the single-stream APB front end.
- Each transaction is framed by `busy`. The first byte is a command header carrying a read/write bit and the start address.
- Writes stream data bytes onto the bus. Reads take a length byte and return PRDATA bytes on the out stream, marking the final one with `out_last`.
- Sits between the serial/SPI byte-stream layer and the peripheral APB register bank.

Parameters:
- ADDR_W, 5, APB address width; legal range 1..7.
- ADDR_INC, 1, 1 = address post-increments after each access (wraps modulo 2^ADDR_W); 0 = fixed address (FIFO-register mode).
- TIMEOUT, 15, PREADY wait limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- in_data  in  8  inbound stream byte
- in_valid  in  1  inbound byte valid
- in_ready  out  1  bridge accepts byte this cycle
- in_last  in  1  marks final inbound write-data byte
- out_data  out  8  read data byte
- out_valid  out  1  read data valid
- out_ready  in  1  downstream accepts read byte
- out_last  out  1  final byte of a read burst
- busy  in  1  transaction frame; high for the whole transaction
- PSEL  out  1  APB select
- PADDR  out  ADDR_W  APB address
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- PREADY  in  1  APB ready
- err  out  1  sticky timeout flag; cleared on rising busy

Behaviour:
- Reset: all outputs 0; FSM in IDLE; address and count registers 0.
- A byte transfers when in_valid & in_ready. A read byte transfers when out_valid & out_ready.
- Header byte: bit7 = 1 read, 0 write. bits[ADDR_W-1:0] = start address. Unused bits are ignored.
- FSM states:
  - IDLE: in_ready = busy. On a header transfer, latch address. Go to RLEN if read, else WDATA.
  - RLEN: in_ready = 1. Latch the length byte; 0 encodes 256 bytes (9-bit count). Go to RSETUP.
  - WDATA: in_ready = 1. Latch the byte into PWDATA and record in_last. Go to WSETUP.
  - WSETUP: PSEL = 1, PWRITE = 1, PENABLE = 0, in_ready = 0, for exactly one cycle. Go to WACCESS.
  - WACCESS: PSEL = PENABLE = 1, held until PREADY. Then apply the address update. Go to DONE if the recorded in_last was set, else WDATA.
  - RSETUP/RACCESS: same timing as the write pair with PWRITE = 0. On PREADY, capture PRDATA into out_data and go to RPUSH.
  - RPUSH: out_valid = 1; out_last = (count == 1). On transfer, decrement count and apply the address update. Go to DONE when count reaches 0, else RSETUP.
  - DONE: in_ready = 1; inbound bytes are accepted and discarded. No bus activity.
- Address update: PADDR <= PADDR + ADDR_INC, truncated to ADDR_W bits. Address all-ones wraps to 0.
- Minimum access: 2 cycles per APB transfer; each added wait cycle holds PREADY low for one more cycle.
- APB outputs are registered. PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
- busy low:
  - In IDLE, RLEN, WDATA, RPUSH or DONE: return to IDLE on the next cycle and drop any pending out byte (out_valid falls).
  - In SETUP or ACCESS: the APB access is never cut short. It completes (PREADY or timeout), then the FSM goes to IDLE and any read data is discarded.
- busy rising while the FSM is still finishing an aborted access: the new header is not accepted (in_ready = 0) until the FSM reaches IDLE.
- Back-to-back: a new header is taken in the cycle IDLE is entered, provided busy is high.
- in_last on a header or length byte is ignored.

Optional Feature:
- Macro: STREAM_APB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACCESS states.
  - If PREADY has not been seen after TIMEOUT ACCESS cycles, the access is terminated and err is set.
  - Terminated write: continue as if completed.
  - Terminated read: push 8'hFF as the data byte.
  - err stays set until busy rises or RESET.
- Undefined: no counter; ACCESS waits indefinitely; err is tied to 0.

Test Plan:
- Write burst: busy = 1, bytes 0x03, 0xA1, 0xB2, 0xC3 (last on 0xC3) -> three APB writes, PADDR = 3, 4, 5, PWDATA = A1, B2, C3, each 2 cycles with PREADY = 1, then DONE.
- Read burst with back-pressure: header 0x9E, length 0x03, ADDR_W = 5, PRDATA = addr + 0x40, out_ready toggling -> out bytes 0x5E, 0x5F, 0x40 (address wraps 1F -> 00); out_last only on the third byte; no APB access is started while a byte is pending.
- Fixed-address mode (ADDR_INC = 0): write header 0x07 plus four data bytes -> four writes, all at PADDR = 7.
- Wait states plus abort: PREADY low 3 cycles on the 2nd write, busy dropped mid-ACCESS -> access finishes when PREADY rises, no further writes, FSM returns to IDLE, next header accepted.
- Length 0: header 0x80, length 0x00 -> exactly 256 reads; out_last on the 256th byte.
- Timeout (macro defined, TIMEOUT = 15): PREADY held low -> access ends after 15 ACCESS cycles, out byte 0xFF, err = 1, err cleared on the next busy rise. Asynchronous RESET pulse mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/stream_to_apb_bridge.sv
// rtl/stream_to_apb_bridge.sv - byte-stream to APB master bridge; optional PREADY timeout via STREAM_APB_TIMEOUT_EN
module stream_to_apb_bridge #(
    parameter int ADDR_W   = 5,
    parameter int ADDR_INC = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    input  logic              busy,
    output logic              PSEL,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RLEN,
        S_WDATA,
        S_WSETUP,
        S_WACCESS,
        S_RSETUP,
        S_RACCESS,
        S_RPUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_count;
    logic              r_last;
    logic              r_abort;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [7:0]        r_pwdata;
    logic [7:0]        r_out_data;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_in_access;
    logic              w_in_setup;
    logic              w_acc_done;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_in_access = (r_state == S_WACCESS) || (r_state == S_RACCESS);
    assign w_in_setup  = (r_state == S_WSETUP) || (r_state == S_RSETUP);
    assign w_acc_done  = w_in_access && (PREADY || w_timeout);
    assign w_in_xfer   = in_valid && w_in_ready;
    assign w_out_xfer  = (r_state == S_RPUSH) && out_ready;
    assign w_addr_next = r_addr + ADDR_W'(ADDR_INC);

    // in_ready is forced low while RESET is held so every output reads 0 during reset
    assign in_ready  = w_in_ready & ~RESET;
    assign out_valid = (r_state == S_RPUSH);
    assign out_last  = (r_state == S_RPUSH) && (r_count == 9'd1);
    assign out_data  = r_out_data;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_addr;
    assign PWDATA    = r_pwdata;

`ifdef STREAM_APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_err;
    logic          r_busy_d;

    // terminate on the TIMEOUT-th ACCESS cycle if PREADY still has not arrived
    assign w_timeout = w_in_access && !PREADY && (r_tcnt == TW'(TIMEOUT - 1));
    assign err       = r_err;

    // count ACCESS cycles of the current transfer, restart for every new access
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tcnt <= '0;
        end else if (w_in_access && !w_acc_done) begin
            r_tcnt <= r_tcnt + TW'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    // sticky error flag, cleared when a new transaction frame opens
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_err    <= 1'b0;
            r_busy_d <= 1'b0;
        end else begin
            r_busy_d <= busy;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (busy && !r_busy_d) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and stream handshake decode
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = busy;
                if (busy && in_valid) begin
                    w_next = in_data[7] ? S_RLEN : S_WDATA;
                end
            end
            S_RLEN: begin
                w_in_ready = 1'b1;
                if (!busy) begin
                    w_next = S_IDLE;
                end else if (in_valid) begin
                    w_next = S_RSETUP;
                end
            end
            S_WDATA: begin
                w_in_ready = 1'b1;
                if (!busy) begin
                    w_next = S_IDLE;
                end else if (in_valid) begin
                    w_next = S_WSETUP;
                end
            end
            S_WSETUP: begin
                w_next = S_WACCESS;
            end
            S_WACCESS: begin
                if (w_acc_done) begin
                    if (r_abort || !busy) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = r_last ? S_DONE : S_WDATA;
                    end
                end
            end
            S_RSETUP: begin
                w_next = S_RACCESS;
            end
            S_RACCESS: begin
                if (w_acc_done) begin
                    w_next = (r_abort || !busy) ? S_IDLE : S_RPUSH;
                end
            end
            S_RPUSH: begin
                if (!busy) begin
                    w_next = S_IDLE;
                end else if (out_ready) begin
                    w_next = (r_count == 9'd1) ? S_DONE : S_RSETUP;
                end
            end
            S_DONE: begin
                w_in_ready = 1'b1;
                if (!busy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // APB control lines registered from the upcoming state so they align with SETUP/ACCESS
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
        end else begin
            r_psel    <= (w_next == S_WSETUP) || (w_next == S_WACCESS) ||
                         (w_next == S_RSETUP) || (w_next == S_RACCESS);
            r_penable <= (w_next == S_WACCESS) || (w_next == S_RACCESS);
            r_pwrite  <= (w_next == S_WSETUP) || (w_next == S_WACCESS);
        end
    end

    // address, count, write data and read data capture
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr     <= '0;
            r_count    <= 9'd0;
            r_last     <= 1'b0;
            r_pwdata   <= 8'd0;
            r_out_data <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_addr <= in_data[ADDR_W-1:0];
                    end
                end
                S_RLEN: begin
                    if (w_in_xfer && busy) begin
                        r_count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    end
                end
                S_WDATA: begin
                    if (w_in_xfer && busy) begin
                        r_pwdata <= in_data;
                        r_last   <= in_last;
                    end
                end
                S_WACCESS: begin
                    if (w_acc_done) begin
                        r_addr <= w_addr_next;
                    end
                end
                S_RACCESS: begin
                    if (w_acc_done) begin
                        r_out_data <= PREADY ? PRDATA : 8'hFF;
                    end
                end
                S_RPUSH: begin
                    if (w_out_xfer && busy) begin
                        r_count <= r_count - 9'd1;
                        r_addr  <= w_addr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // remember that busy dropped during an APB access so the FSM returns to IDLE afterwards
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_abort <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_abort <= 1'b0;
        end else if (!busy && (w_in_setup || w_in_access)) begin
            r_abort <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_to_apb_bridge.sv
// tb/tb_stream_to_apb_bridge.sv - scoreboard bench for stream_to_apb_bridge
module tb_stream_to_apb_bridge;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_last = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy = 1'b0;
    logic       PSEL;
    logic [4:0] PADDR;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
    } apb_t;

    apb_t       apb_q[$];
    logic [8:0] out_q[$];

    int   acc_num  = 0;
    int   acc_cyc  = 0;
    int   wait_at  = -1;
    int   wait_len = 0;
    int   or_mode  = 0;
    logic       setup_w = 1'b0;
    logic [4:0] setup_a = 5'd0;

    stream_to_apb_bridge #(
        .ADDR_W   (5),
        .ADDR_INC (1),
        .TIMEOUT  (15)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // slave: read data = address + 0x40; PREADY held low wait_len cycles on access number wait_at
    assign PRDATA = 8'h40 + {3'b000, PADDR};
    assign PREADY = !((acc_num == wait_at) && (acc_cyc < wait_len));

    always @(posedge CLK) begin
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                acc_num <= acc_num + 1;
                acc_cyc <= 0;
            end else begin
                acc_cyc <= acc_cyc + 1;
            end
        end else begin
            acc_cyc <= 0;
        end
    end

    always @(posedge CLK) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every completed APB access and every out-stream transfer
    always @(negedge CLK) begin
        apb_t     e;
        logic [8:0] o;
        if (!RESET) begin
            if (PSEL && !PENABLE) begin
                setup_w = PWRITE;
                setup_a = PADDR;
            end
            if (PSEL && PENABLE && PREADY) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected: got w=%0b a=%h", PWRITE, PADDR);
                end else begin
                    e = apb_q.pop_front();
                    chk("apb_access", {18'd0, PWRITE, PADDR, (PWRITE ? PWDATA : PRDATA)}, {18'd0, e});
                    chk("apb_stable", {26'd0, PWRITE, PADDR}, {26'd0, setup_w, setup_a});
                end
            end
            if (out_valid) begin
                chk("no_bus_while_pending", {31'd0, PSEL}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %h last %0b", out_data, out_last);
                end else begin
                    o = out_q.pop_front();
                    chk("out_byte", {23'd0, out_last, out_data}, {23'd0, o});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge CLK);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((apb_q.size() != 0 || out_q.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk(name, apb_q.size() + out_q.size(), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        #3;
        chk("reset_outputs",
            {9'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, out_valid, out_last, out_data, err, in_ready},
            32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // write burst 0x03, A1, B2, C3(last), then a discarded byte in DONE
        apb_q.push_back({1'b1, 5'h03, 8'hA1});
        apb_q.push_back({1'b1, 5'h04, 8'hB2});
        apb_q.push_back({1'b1, 5'h05, 8'hC3});
        busy = 1'b1;
        send(8'h03, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hC3, 1'b1);
        drain("write_burst_drain");
        send(8'hEE, 1'b1);
        @(negedge CLK);
        busy = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // read burst with address wrap and toggling out_ready
        apb_q.push_back({1'b0, 5'h1E, 8'h5E});
        apb_q.push_back({1'b0, 5'h1F, 8'h5F});
        apb_q.push_back({1'b0, 5'h00, 8'h40});
        out_q.push_back({1'b0, 8'h5E});
        out_q.push_back({1'b0, 8'h5F});
        out_q.push_back({1'b1, 8'h40});
        or_mode = 1;
        busy = 1'b1;
        send(8'h9E, 1'b1);
        send(8'h03, 1'b1);
        drain("read_burst_drain");
        or_mode = 0;
        busy = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // wait states on the second write, busy dropped mid-ACCESS and re-raised early
        wait_at  = acc_num + 1;
        wait_len = 3;
        apb_q.push_back({1'b1, 5'h02, 8'h11});
        apb_q.push_back({1'b1, 5'h03, 8'h22});
        apb_q.push_back({1'b1, 5'h10, 8'h33});
        busy = 1'b1;
        send(8'h02, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        n = 0;
        while (!(PSEL && PENABLE && !PREADY) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_state_seen", {31'd0, (n < 50)}, 32'd1);
        busy = 1'b0;
        @(negedge CLK);
        busy = 1'b1;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        send(8'h10, 1'b0);
        send(8'h33, 1'b1);
        drain("abort_drain");
        busy = 1'b0;
        wait_len = 0;
        chk("err_default", {31'd0, err}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);

        // length 0 means 256 reads starting at address 0
        for (int i = 0; i < 256; i++) begin
            apb_q.push_back({1'b0, 5'(i % 32), 8'(8'h40 + (i % 32))});
            out_q.push_back({(i == 255), 8'(8'h40 + (i % 32))});
        end
        busy = 1'b1;
        send(8'h80, 1'b0);
        send(8'h00, 1'b1);
        drain("len0_drain");
        busy = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

`ifdef STREAM_APB_TIMEOUT_EN
        begin : tmo_test
            int acc;
            acc      = 0;
            wait_at  = acc_num;
            wait_len = 1000;
            out_q.push_back({1'b1, 8'hFF});
            busy = 1'b1;
            send(8'h85, 1'b0);
            send(8'h01, 1'b0);
            n = 0;
            while (!out_valid && n < 200) begin
                @(negedge CLK);
                if (PSEL && PENABLE) acc++;
                n++;
            end
            chk("tmo_cycles", acc, 32'd15);
            drain("tmo_drain");
            chk("tmo_err_set", {31'd0, err}, 32'd1);
            wait_len = 0;
            busy = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            busy = 1'b1;
            @(negedge CLK);
            #1;
            chk("tmo_err_clear", {31'd0, err}, 32'd0);
            busy = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
        end
`endif

        // asynchronous reset while a read byte is pending
        or_mode = 2;
        apb_q.push_back({1'b0, 5'h01, 8'h41});
        busy = 1'b1;
        send(8'h81, 1'b0);
        send(8'h02, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("pending_before_reset", {31'd0, out_valid}, 32'd1);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_outputs",
            {9'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, out_valid, out_last, out_data, err, in_ready},
            32'd0);
        busy = 1'b0;
        or_mode = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        chk("apb_q_empty", apb_q.size(), 32'd0);
        chk("out_q_empty", out_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
